pipe_perf_monitor: RTL and testbench
====================================

Name: pipe_perf_monitor

Overview:
Synthesizable per-cycle performance monitor for the pipelined CPU. It counts pipeline events per channel (stall, flush, branch-taken, load-use, ...) and elapsed run cycles, and stops at a programmable cycle limit. It also buffers committed PC values in a trace FIFO for bench or debug-port readout. It sits beside the CPU top and is fed by hazard/control strobes and the PC register output.

Parameters:
NUM_EVT, 4, number of independent event channels (1..16)
CNT_W, 32, width of every event counter and of the cycle counter
MAX_CYCLES, 30, cycle limit in RUN; 0 = no limit
PC_W, 32, width of traced PC
TRACE_DEPTH, 8, trace FIFO entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  level; enables counting (IDLE->RUN)
clear_i  in  1  pulse; zero all counters, FIFO, flags; return to IDLE
evt_i  in  NUM_EVT  one strobe per channel, sampled each cycle
pc_i  in  PC_W  PC value to trace
pc_valid_i  in  1  pc_i is valid this cycle
snap_i  in  1  pulse; copy live counters into shadow bank
rd_sel_i  in  $clog2(NUM_EVT) (min 1)  shadow channel select
rd_data_o  out  CNT_W  shadow counter of channel rd_sel_i, registered
cycle_o  out  CNT_W  live cycle counter
done_o  out  1  cycle limit reached
state_o  out  2  00 IDLE, 01 RUN, 10 DONE
trace_pc_o  out  PC_W  FIFO head
trace_valid_o  out  1  FIFO non-empty
trace_ready_i  in  1  consumer accepts head
trace_ovf_o  out  1  sticky: push dropped while full

Behaviour:
- Reset and clear_i: all outputs 0, counters/shadows 0, FIFO empty, state IDLE. rst_i has priority over clear_i; clear_i has priority over all other inputs.
- FSM: IDLE->RUN when start_i=1. RUN->IDLE when start_i=0, counters hold. RUN->DONE on the edge where cycle_o becomes MAX_CYCLES (MAX_CYCLES!=0). DONE is left only by reset or clear_i.
- RUN: cycle_o increments by 1 per clock. Event counter k increments when evt_i[k]=1. Counting is active only in RUN, including the transition edge into DONE. No counting in IDLE or DONE.
- done_o = (state==DONE), registered.
- Snapshot: on snap_i, shadow[k] takes the live counter's pre-edge value; an increment on the same edge is not captured. snap_i is honoured in any state.
- rd_data_o = shadow[rd_sel_i] registered, 1-cycle latency. rd_sel_i >= NUM_EVT returns 0.
- Trace FIFO: push when state==RUN && pc_valid_i. Pop when trace_valid_o && trace_ready_i. trace_pc_o and trace_valid_o come straight from registers (first-word-fall-through, 1-cycle push-to-valid).
- FIFO full, push without pop: entry dropped, trace_ovf_o set (sticky until reset/clear).
- FIFO full, push with pop: both happen, no overflow.
- FIFO empty, pop: ignored.
- Pointers are $clog2(TRACE_DEPTH)+1 bits and wrap modulo 2*TRACE_DEPTH.
- Counter limit: behaviour at all-ones depends on the optional feature below.

Optional Feature:
PERF_MON_SAT_EN
- Defined: event and cycle counters saturate at 2^CNT_W-1. The cycle-limit compare still applies.
- Undefined: counters wrap modulo 2^CNT_W.

Decomposition:
- Package perf_mon_pkg: state encoding constants (ST_IDLE, ST_RUN, ST_DONE), state typedef, clog2-based width helper constants.
- Sub-module perf_trace_fifo (parametrised PC_W, TRACE_DEPTH): push/pop/full/empty/overflow.
- Counters and FSM stay in the top.

Test Plan:
- MAX_CYCLES=30, start_i held high, evt_i[0] toggled every other cycle -> DONE after 30 RUN cycles; cycle_o=30, counter0=15, done_o=1; further evt_i ignored.
- snap_i on the same edge as evt_i[1] while counter1=7 -> shadow1=7, live=8; rd_sel_i=1 -> rd_data_o=7 one cycle later.
- TRACE_DEPTH=8, 10 pushes with trace_ready_i=0 -> 8 entries held, trace_ovf_o=1; draining yields the first 8 PCs in order.
- FIFO full, push and pop on the same cycle -> occupancy stays 8, trace_ovf_o stays 0.
- CNT_W=4, 20 events: PERF_MON_SAT_EN defined -> 15; undefined -> 4.
- clear_i mid-RUN and rst_i in DONE -> everything zero, state IDLE next cycle; start_i restarts counting from 0.

Source files
------------

// File: rtl/perf_mon_pkg.sv
// Shared types and width helpers for the pipeline performance monitor.
// Includes the state encoding and pointer/select width functions.
package perf_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // FIFO pointers carry one extra wrap bit to tell full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/perf_trace_fifo.sv
// First-word-fall-through trace FIFO for committed PCs; head and valid are registered.
// A push into a full FIFO without a simultaneous pop is dropped and flagged sticky.
module perf_trace_fifo
  import perf_mon_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int TRACE_DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            push_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic            pop_i,
  output logic [PC_W-1:0] head_o,
  output logic            valid_o,
  output logic            ovf_o
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int PW = ptr_width(TRACE_DEPTH);

  logic [PC_W-1:0] mem_reg [TRACE_DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic [PC_W-1:0] head_reg, head_next;
  logic            valid_reg, ovf_reg;
  logic            full, do_push, do_pop;

  assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign do_pop  = pop_i && valid_reg;
  assign do_push = push_i && (!full || do_pop);

  assign wr_ptr_next = do_push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
  assign rd_ptr_next = do_pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;

  // The new head may be the word being written on this very edge.
  assign head_next = (do_push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]))
                     ? pc_i : mem_reg[rd_ptr_next[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= pc_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      head_reg   <= '0;
      valid_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      head_reg   <= head_next;
      valid_reg  <= (wr_ptr_next != rd_ptr_next);
      if (push_i && full && !do_pop) ovf_reg <= 1'b1;
    end
  end

  assign head_o  = head_reg;
  assign valid_o = valid_reg;
  assign ovf_o   = ovf_reg;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Per-cycle pipeline event counters, cycle limit FSM, snapshot bank and PC trace FIFO.
// Optional PERF_MON_SAT_EN: counters saturate at all-ones instead of wrapping.
module pipe_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int NUM_EVT     = 4,
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 30,
  parameter int PC_W        = 32,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          clear_i,
  input  logic [NUM_EVT-1:0]            evt_i,
  input  logic [PC_W-1:0]               pc_i,
  input  logic                          pc_valid_i,
  input  logic                          snap_i,
  input  logic [sel_width(NUM_EVT)-1:0] rd_sel_i,
  output logic [CNT_W-1:0]              rd_data_o,
  output logic [CNT_W-1:0]              cycle_o,
  output logic                          done_o,
  output logic [1:0]                    state_o,
  output logic [PC_W-1:0]               trace_pc_o,
  output logic                          trace_valid_o,
  input  logic                          trace_ready_i,
  output logic                          trace_ovf_o
);

  localparam int               SEL_W     = sel_width(NUM_EVT);
  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(MAX_CYCLES);
  localparam logic [SEL_W:0]   NUM_EVT_L = (SEL_W + 1)'(NUM_EVT);

  state_t           state_reg;
  logic             done_reg;
  logic [CNT_W-1:0] cycle_reg, cycle_next;
  logic [CNT_W-1:0] evt_cnt_reg [NUM_EVT];
  logic [CNT_W-1:0] shadow_reg  [NUM_EVT];
  logic [CNT_W-1:0] rd_data_reg;
  logic             count_en;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef PERF_MON_SAT_EN
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  // Dropping start_i leaves RUN on that edge without counting it.
  assign count_en   = (state_reg == ST_RUN) && start_i;
  assign cycle_next = bump(cycle_reg);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
      cycle_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (start_i) state_reg <= ST_RUN;
        ST_RUN: begin
          if (!start_i) begin
            state_reg <= ST_IDLE;
          end else begin
            cycle_reg <= cycle_next;
            if ((MAX_CYCLES != 0) && (cycle_next == LIMIT)) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        ST_DONE: state_reg <= ST_DONE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_evt
      always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
          evt_cnt_reg[gi] <= '0;
          shadow_reg[gi]  <= '0;
        end else begin
          if (snap_i) shadow_reg[gi] <= evt_cnt_reg[gi];
          if (count_en && evt_i[gi]) evt_cnt_reg[gi] <= bump(evt_cnt_reg[gi]);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rd_data_reg <= '0;
    end else if ({1'b0, rd_sel_i} < NUM_EVT_L) begin
      rd_data_reg <= shadow_reg[rd_sel_i];
    end else begin
      rd_data_reg <= '0;
    end
  end

  perf_trace_fifo #(
    .PC_W        (PC_W),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clear_i),
    .push_i  ((state_reg == ST_RUN) && pc_valid_i),
    .pc_i    (pc_i),
    .pop_i   (trace_ready_i),
    .head_o  (trace_pc_o),
    .valid_o (trace_valid_o),
    .ovf_o   (trace_ovf_o)
  );

  assign rd_data_o = rd_data_reg;
  assign cycle_o   = cycle_reg;
  assign done_o    = done_reg;
  assign state_o   = state_reg;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: limit FSM, snapshot, trace FIFO, saturation, clear/reset.
// A second 4-bit-counter instance with no cycle limit covers counter wrap/saturation.
module tb_pipe_perf_monitor;

`ifdef PERF_MON_SAT_EN
  localparam logic [3:0] SAT_EXP = 4'd15;
`else
  localparam logic [3:0] SAT_EXP = 4'd4;
`endif

  logic        clk = 1'b0;
  logic        rst, start, clear, pc_valid, snap, ready;
  logic [3:0]  evt;
  logic [31:0] pc;
  logic [1:0]  rd_sel;

  logic [31:0] rd_data, cycle, trace_pc;
  logic        done, trace_valid, trace_ovf;
  logic [1:0]  state;

  logic [3:0]  b_rd_data, b_cycle;
  logic [31:0] b_trace_pc;
  logic        b_done, b_trace_valid, b_trace_ovf;
  logic [1:0]  b_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_perf_monitor #(
    .NUM_EVT(4), .CNT_W(32), .MAX_CYCLES(30), .PC_W(32), .TRACE_DEPTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
    .pc_i(pc), .pc_valid_i(pc_valid), .snap_i(snap), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data), .cycle_o(cycle), .done_o(done), .state_o(state),
    .trace_pc_o(trace_pc), .trace_valid_o(trace_valid), .trace_ready_i(ready),
    .trace_ovf_o(trace_ovf)
  );

  pipe_perf_monitor #(
    .NUM_EVT(4), .CNT_W(4), .MAX_CYCLES(0), .PC_W(32), .TRACE_DEPTH(8)
  ) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
    .pc_i(pc), .pc_valid_i(pc_valid), .snap_i(snap), .rd_sel_i(rd_sel),
    .rd_data_o(b_rd_data), .cycle_o(b_cycle), .done_o(b_done), .state_o(b_state),
    .trace_pc_o(b_trace_pc), .trace_valid_o(b_trace_valid), .trace_ready_i(ready),
    .trace_ovf_o(b_trace_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (cycle !== 32'd0) begin failures++; $display("FAIL reset_cycle got=%0d exp=0", cycle); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d exp=0", done); end
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL reset_trace_valid got=%0d exp=0", trace_valid); end
    checks++; if (trace_ovf !== 1'b0) begin failures++; $display("FAIL reset_trace_ovf got=%0d exp=0", trace_ovf); end
    checks++; if (trace_pc !== 32'd0) begin failures++; $display("FAIL reset_trace_pc got=%0h exp=0", trace_pc); end
    rst = 1'b0;
    step();
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL idle_hold got=%0d exp=0", state); end
    $display("test_reset complete");
  endtask

  task automatic test_run_limit();
    start = 1'b1;
    step();
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL run_enter got=%0d exp=1", state); end
    checks++; if (cycle !== 32'd0) begin failures++; $display("FAIL run_enter_cycle got=%0d exp=0", cycle); end
    for (int i = 0; i < 30; i++) begin
      evt = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      step();
    end
    checks++; if (state !== 2'b10) begin failures++; $display("FAIL limit_state got=%0d exp=2", state); end
    checks++; if (cycle !== 32'd30) begin failures++; $display("FAIL limit_cycle got=%0d exp=30", cycle); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL limit_done got=%0d exp=1", done); end
    evt = 4'b1111;
    repeat (3) step();
    evt = 4'b0000;
    checks++; if (cycle !== 32'd30) begin failures++; $display("FAIL done_cycle_hold got=%0d exp=30", cycle); end
    checks++; if (state !== 2'b10) begin failures++; $display("FAIL done_sticky got=%0d exp=2", state); end
    snap = 1'b1; rd_sel = 2'd0;
    step();
    snap = 1'b0;
    step();
    checks++; if (rd_data !== 32'd15) begin failures++; $display("FAIL limit_evt0 got=%0d exp=15", rd_data); end
    rd_sel = 2'd1;
    step();
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL limit_evt1 got=%0d exp=0", rd_data); end
    $display("test_run_limit complete");
  endtask

  task automatic test_snapshot();
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL clear_state got=%0d exp=0", state); end
    checks++; if (cycle !== 32'd0) begin failures++; $display("FAIL clear_cycle got=%0d exp=0", cycle); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL clear_done got=%0d exp=0", done); end
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL clear_rd_data got=%0d exp=0", rd_data); end
    step();
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL snap_run got=%0d exp=1", state); end
    evt = 4'b0010;
    repeat (7) step();
    snap = 1'b1;
    step();
    snap = 1'b0; evt = 4'b0000; rd_sel = 2'd1;
    step();
    checks++; if (rd_data !== 32'd7) begin failures++; $display("FAIL snap_pre_edge got=%0d exp=7", rd_data); end
    snap = 1'b1;
    step();
    snap = 1'b0;
    step();
    checks++; if (rd_data !== 32'd8) begin failures++; $display("FAIL snap_live got=%0d exp=8", rd_data); end
    checks++; if (cycle !== 32'd11) begin failures++; $display("FAIL snap_cycle got=%0d exp=11", cycle); end
    start = 1'b0;
    step();
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL stop_state got=%0d exp=0", state); end
    step();
    checks++; if (cycle !== 32'd11) begin failures++; $display("FAIL stop_hold got=%0d exp=11", cycle); end
    $display("test_snapshot complete");
  endtask

  task automatic test_trace_overflow();
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0;
    step();
    ready = 1'b0; pc_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pc = 32'h100 + i;
      step();
    end
    pc_valid = 1'b0;
    checks++; if (trace_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%0d exp=1", trace_valid); end
    checks++; if (trace_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0d exp=1", trace_ovf); end
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (trace_valid !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d] got=%0d exp=1", i, trace_valid); end
      checks++; if (trace_pc !== 32'h100 + i) begin failures++; $display("FAIL drain_pc[%0d] got=%0h exp=%0h", i, trace_pc, 32'h100 + i); end
      step();
    end
    ready = 1'b0;
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0d exp=0", trace_valid); end
    checks++; if (trace_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0d exp=1", trace_ovf); end
    $display("test_trace_overflow complete");
  endtask

  task automatic test_full_push_pop();
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0;
    step();
    pc_valid = 1'b1; ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pc = 32'h200 + i;
      step();
    end
    checks++; if (trace_pc !== 32'h200) begin failures++; $display("FAIL full_head got=%0h exp=200", trace_pc); end
    checks++; if (trace_ovf !== 1'b0) begin failures++; $display("FAIL full_no_ovf got=%0d exp=0", trace_ovf); end
    pc = 32'h208; ready = 1'b1;
    step();
    pc_valid = 1'b0;
    checks++; if (trace_ovf !== 1'b0) begin failures++; $display("FAIL pushpop_ovf got=%0d exp=0", trace_ovf); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (trace_valid !== 1'b1) begin failures++; $display("FAIL pp_valid[%0d] got=%0d exp=1", i, trace_valid); end
      checks++; if (trace_pc !== 32'h200 + i) begin failures++; $display("FAIL pp_pc[%0d] got=%0h exp=%0h", i, trace_pc, 32'h200 + i); end
      step();
    end
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL pp_empty got=%0d exp=0", trace_valid); end
    step();
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL empty_pop got=%0d exp=0", trace_valid); end
    ready = 1'b0; pc_valid = 1'b1; pc = 32'h300;
    step();
    pc_valid = 1'b0;
    checks++; if (trace_valid !== 1'b1) begin failures++; $display("FAIL repush_valid got=%0d exp=1", trace_valid); end
    checks++; if (trace_pc !== 32'h300) begin failures++; $display("FAIL repush_pc got=%0h exp=300", trace_pc); end
    $display("test_full_push_pop complete");
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b1; evt = 4'b0000;
    step();
    evt = 4'b0001;
    repeat (20) step();
    evt = 4'b0000; start = 1'b0;
    step();
    checks++; if (b_state !== 2'b00) begin failures++; $display("FAIL sat_state got=%0d exp=0", b_state); end
    snap = 1'b1; rd_sel = 2'd0;
    step();
    snap = 1'b0;
    step();
    checks++; if (b_rd_data !== SAT_EXP) begin failures++; $display("FAIL sat_evt0 got=%0d exp=%0d", b_rd_data, SAT_EXP); end
    checks++; if (b_cycle !== SAT_EXP) begin failures++; $display("FAIL sat_cycle got=%0d exp=%0d", b_cycle, SAT_EXP); end
    checks++; if (rd_data !== 32'd20) begin failures++; $display("FAIL wide_evt0 got=%0d exp=20", rd_data); end
    checks++; if (cycle !== 32'd20) begin failures++; $display("FAIL wide_cycle got=%0d exp=20", cycle); end
    $display("test_saturation complete");
  endtask

  task automatic test_clear_reset();
    start = 1'b1;
    step();
    evt = 4'b1111;
    repeat (5) step();
    clear = 1'b1;
    step();
    clear = 1'b0; evt = 4'b0000;
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL midrun_clear_state got=%0d exp=0", state); end
    checks++; if (cycle !== 32'd0) begin failures++; $display("FAIL midrun_clear_cycle got=%0d exp=0", cycle); end
    step();
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL restart_state got=%0d exp=1", state); end
    checks++; if (cycle !== 32'd0) begin failures++; $display("FAIL restart_cycle0 got=%0d exp=0", cycle); end
    step();
    checks++; if (cycle !== 32'd1) begin failures++; $display("FAIL restart_cycle1 got=%0d exp=1", cycle); end
    snap = 1'b1; rd_sel = 2'd2;
    step();
    snap = 1'b0;
    step();
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL cleared_evt2 got=%0d exp=0", rd_data); end
    for (int n = 0; n < 40; n++) begin
      if (done) break;
      step();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL wait_done got=%0d exp=1", done); end
    checks++; if (cycle !== 32'd30) begin failures++; $display("FAIL done_cycle got=%0d exp=30", cycle); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL done_rst_state got=%0d exp=0", state); end
    checks++; if (cycle !== 32'd0) begin failures++; $display("FAIL done_rst_cycle got=%0d exp=0", cycle); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_rst_done got=%0d exp=0", done); end
    step();
    step();
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL rst_restart_state got=%0d exp=1", state); end
    checks++; if (cycle !== 32'd1) begin failures++; $display("FAIL rst_restart_cycle got=%0d exp=1", cycle); end
    start = 1'b0;
    $display("test_clear_reset complete");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; evt = 4'b0000;
    pc = 32'd0; pc_valid = 1'b0; snap = 1'b0; rd_sel = 2'd0; ready = 1'b0;
    test_reset();
    test_run_limit();
    test_snapshot();
    test_trace_overflow();
    test_full_push_pop();
    test_saturation();
    test_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
